burst_mem_responder: RTL and testbench

Synthesizable responder for the physical-memory (pmem) burst interface driven by the cache hierarchy of the `mp4` core. It accepts line-sized read and write requests and serves them as 4-beat, 64-bit bursts from an internal line store after a programmable latency. It stands in for the testbench burst memory in FPGA and emulation builds, and it checks that the initiator follows the protocol.

---
 rtl/pmem_pkg.sv | 22 ++
 rtl/pmem_line_store.sv | 47 ++++
 rtl/burst_mem_responder.sv | 153 +++++++++++++++
 tb/tb_burst_mem_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// pmem_pkg: shared definitions for the pmem burst responder.
//   BURST_LEN        beats per line burst
//   BEAT_W           width of one data beat
//   LINE_OFFSET_BITS byte-offset bits ignored in a line address
//   pmem_state_t     responder state encoding
//   beat_t           beat index within a burst
package pmem_pkg;

    localparam int unsigned BURST_LEN        = 4;
    localparam int unsigned BEAT_W           = 64;
    localparam int unsigned LINE_OFFSET_BITS = 5;

    typedef logic [1:0] beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } pmem_state_t;

endpackage

// File: rtl/pmem_line_store.sv
// pmem_line_store: 1R1W line store, NUM_LINES x BURST_LEN beats of BEAT_W bits,
// addressed as {line, beat}.
//   clk    clock
//   we     write enable, synchronous write of wdata at waddr
//   waddr  write address {line, beat}
//   wdata  write beat
//   re     read enable; when low the registered read data returns to 0
//   raddr  read address {line, beat}
//   rdata  registered read data
module pmem_line_store
    import pmem_pkg::*;
#(
    parameter int unsigned NUM_LINES = 256
) (
    input  logic                                 clk,
    input  logic                                 we,
    input  logic [$clog2(NUM_LINES*BURST_LEN)-1:0] waddr,
    input  logic [BEAT_W-1:0]                    wdata,
    input  logic                                 re,
    input  logic [$clog2(NUM_LINES*BURST_LEN)-1:0] raddr,
    output logic [BEAT_W-1:0]                    rdata
);

    localparam int unsigned DEPTH = NUM_LINES * BURST_LEN;

    // Contents are deliberately not reset.
    logic [BEAT_W-1:0] mem [DEPTH];
    logic [BEAT_W-1:0] rdata_q;
    logic [BEAT_W-1:0] rdata_d;

    always_comb begin
        rdata_d = '0;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: serves line read/write requests from the pmem burst
// interface as 4-beat bursts after LATENCY cycles, and flags protocol errors.
//   clk, rst      clock, synchronous active-high reset
//   pmem_read     line read request, held until the burst completes
//   pmem_write    line write request, held until the burst completes
//   pmem_address  byte address, bits [4:0] ignored, upper bits alias
//   pmem_wdata    write beat presented by the initiator
//   pmem_rdata    registered read beat, 0 outside read resp cycles
//   pmem_resp     high for the 4 beat cycles of a burst
//   busy          high whenever not IDLE
//   proto_err     one-cycle pulse after a protocol violation
module burst_mem_responder
    import pmem_pkg::*;
#(
    parameter int unsigned LATENCY   = 8,
    parameter int unsigned NUM_LINES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [BEAT_W-1:0] pmem_wdata,
    output logic [BEAT_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              busy,
    output logic              proto_err
);

    localparam int unsigned LINE_W = $clog2(NUM_LINES);
    localparam int unsigned CNT_W  = $clog2(LATENCY + 1);
    localparam logic [31:0] LINE_MASK = ((32'd1 << LINE_W) - 32'd1) << LINE_OFFSET_BITS;

    pmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    beat_t             beat_q, beat_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              dir_wr_q, dir_wr_d;
    logic              resp_q, resp_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              req_held;
    logic              store_we;
    logic              store_re;
    logic              unused_addr;

    assign unused_addr = ^(pmem_address & ~LINE_MASK);

    // Dropping the latched line (including switching direction) aborts.
    assign req_held = dir_wr_q ? pmem_write : pmem_read;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        line_d   = line_q;
        dir_wr_d = dir_wr_q;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pmem_read && pmem_write) begin
                    err_d = 1'b1;
                end else if (pmem_read || pmem_write) begin
                    dir_wr_d = pmem_write;
                    line_d   = pmem_address[LINE_OFFSET_BITS +: LINE_W];
                    beat_d   = '0;
                    cnt_d    = CNT_W'(LATENCY - 1);
                    // With LATENCY==1 the first resp cycle follows the request edge.
                    state_d  = (LATENCY == 1) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (!req_held) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    // Leaving on the edge where the count reaches 0 keeps WAIT
                    // at LATENCY-1 cycles, so resp starts t0+LATENCY.
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = BURST;
                        beat_d  = '0;
                    end
                end
            end
            BURST: begin
                if (!req_held) begin
                    state_d = IDLE;
                    beat_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == beat_t'(BURST_LEN - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        resp_d = (state_d == BURST);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            beat_q   <= '0;
            line_q   <= '0;
            dir_wr_q <= 1'b0;
            resp_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            line_q   <= line_d;
            dir_wr_q <= dir_wr_d;
            resp_q   <= resp_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    // Read address uses next-state line/beat so the registered read lands
    // in the same cycle as resp.
    assign store_re = !rst && (state_d == BURST) && !dir_wr_d;
    assign store_we = !rst && (state_q == BURST) && dir_wr_q && req_held;

    pmem_line_store #(
        .NUM_LINES(NUM_LINES)
    ) u_store (
        .clk   (clk),
        .we    (store_we),
        .waddr ({line_q, beat_q}),
        .wdata (pmem_wdata),
        .re    (store_re),
        .raddr ({line_d, beat_d}),
        .rdata (pmem_rdata)
    );

    assign pmem_resp = resp_q;
    assign busy      = busy_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
module tb_burst_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;
    logic        busy;
    logic        proto_err;

    int n_total = 0;
    int n_bad   = 0;

    logic [63:0] bt [4];

    always #5 clk = ~clk;

    burst_mem_responder #(
        .LATENCY   (4),
        .NUM_LINES (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .busy         (busy),
        .proto_err    (proto_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request with LATENCY=4: after edge t0+j, resp is expected for
    // j=3..6 (beat j-3) and busy for j=0..7. drop_beat<4 removes the request
    // during that beat's cycle, which must abort at the following edge.
    task automatic burst(input string name, input logic wr, input logic [31:0] addr,
                         input int drop_beat);
        int  b;
        logic in_b;
        pmem_address = addr;
        pmem_read    = !wr;
        pmem_write   = wr;
        for (int j = 0; j <= 8; j++) begin
            step();
            if (j == 1) pmem_address = 32'hDEAD_BEE0;
            b    = j - 3;
            in_b = (j >= 3) && (j <= 6);
            check($sformatf("%s resp j%0d", name, j), 64'(pmem_resp), 64'(in_b));
            check($sformatf("%s busy j%0d", name, j), 64'(busy), 64'(j <= 7));
            check($sformatf("%s perr j%0d", name, j), 64'(proto_err), 64'd0);
            if (in_b) begin
                if (!wr) check($sformatf("%s rdata b%0d", name, b), pmem_rdata, bt[b]);
                else pmem_wdata = bt[b];
                if (b == drop_beat) begin
                    pmem_read  = 1'b0;
                    pmem_write = 1'b0;
                    step();
                    check($sformatf("%s abort resp", name), 64'(pmem_resp), 64'd0);
                    check($sformatf("%s abort busy", name), 64'(busy), 64'd0);
                    check($sformatf("%s abort perr", name), 64'(proto_err), 64'd1);
                    check($sformatf("%s abort rdata", name), pmem_rdata, 64'd0);
                    step();
                    check($sformatf("%s abort perr clr", name), 64'(proto_err), 64'd0);
                    check($sformatf("%s abort idle resp", name), 64'(pmem_resp), 64'd0);
                    return;
                end
            end else begin
                check($sformatf("%s rdata0 j%0d", name, j), pmem_rdata, 64'd0);
            end
            if (j == 7) begin
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
            end
        end
    endtask

    task automatic set_beats(input logic [63:0] b0, input logic [63:0] b1,
                             input logic [63:0] b2, input logic [63:0] b3);
        bt[0] = b0; bt[1] = b1; bt[2] = b2; bt[3] = b3;
    endtask

    initial begin
        // Reset with random inputs
        rst          = 1'b1;
        pmem_read    = 1'($urandom);
        pmem_write   = 1'($urandom);
        pmem_address = $urandom;
        pmem_wdata   = {$urandom, $urandom};
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("rst resp %0d", i), 64'(pmem_resp), 64'd0);
            check($sformatf("rst rdata %0d", i), pmem_rdata, 64'd0);
            check($sformatf("rst busy %0d", i), 64'(busy), 64'd0);
            check($sformatf("rst perr %0d", i), 64'(proto_err), 64'd0);
            pmem_read    = 1'($urandom);
            pmem_write   = 1'($urandom);
            pmem_address = $urandom;
        end
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_wdata = '0;
        rst        = 1'b0;
        step();
        check("idle busy", 64'(busy), 64'd0);

        // Write then read line 0x40, offset and alias reads
        set_beats(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                  64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        burst("wr40", 1'b1, 32'h0000_0040, 4);
        burst("rd40", 1'b0, 32'h0000_0040, 4);
        burst("rd5c", 1'b0, 32'h0000_005C, 4);
        burst("rd240", 1'b0, 32'h0000_0240, 4);

        // Both read and write high in IDLE
        pmem_read    = 1'b1;
        pmem_write   = 1'b1;
        pmem_address = 32'h0000_0040;
        step();
        check("both perr", 64'(proto_err), 64'd1);
        check("both busy", 64'(busy), 64'd0);
        check("both resp", 64'(pmem_resp), 64'd0);
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        step();
        check("both perr clr", 64'(proto_err), 64'd0);
        check("both busy2", 64'(busy), 64'd0);

        // Read dropped after beat 1
        burst("rd40drop", 1'b0, 32'h0000_0040, 2);

        // Full write of 0x80, then a write dropped after beat 1
        set_beats(64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                  64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD);
        burst("wr80", 1'b1, 32'h0000_0080, 4);
        set_beats(64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                  64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888);
        burst("wr80drop", 1'b1, 32'h0000_0080, 2);
        set_beats(64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                  64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD);
        burst("rd80", 1'b0, 32'h0000_0080, 4);

        // Reset during WAIT
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_0040;
        step();
        check("rstw busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        check("rstw busy0", 64'(busy), 64'd0);
        check("rstw resp0", 64'(pmem_resp), 64'd0);
        rst       = 1'b0;
        pmem_read = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("rstw noresp %0d", i), 64'(pmem_resp), 64'd0);
            check($sformatf("rstw idle %0d", i), 64'(busy), 64'd0);
        end
        set_beats(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                  64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        burst("rd40post", 1'b0, 32'h0000_0040, 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
